// File: rtl/esm_instr_buffer.sv
// esm_instr_buffer: circular RV32 instruction buffer publishing per-slot rd/rs1/rs2 for the dependency table.
// Optional ESM_IBUF_STATS_EN adds a saturating input-stall counter on stall_cnt.
module esm_instr_buffer #(
    parameter int BS     = 32,
    parameter int REGNUM = 16,
    parameter int IW     = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [IW-1:0]             in_instr,
    output logic                      alloc_valid,
    output logic [$clog2(BS)-1:0]     alloc_index,
    output logic [$clog2(REGNUM)-1:0] alloc_rd,
    output logic [$clog2(REGNUM)-1:0] alloc_rs1,
    output logic [$clog2(REGNUM)-1:0] alloc_rs2,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [IW-1:0]             out_instr,
    output logic [$clog2(BS)-1:0]     out_index,
    output logic [$clog2(BS+1)-1:0]   count,
    output logic                      full,
    output logic                      empty,
    output logic [15:0]               stall_cnt
);
    localparam int AW = $clog2(BS);
    localparam int RW = $clog2(REGNUM);
    localparam int CW = $clog2(BS + 1);

    logic [IW-1:0] mem [BS];
    logic [AW-1:0] head, tail;
    logic [CW-1:0] cnt;
    logic          push, pop, st_br, imm, upper, op, keep_rd, keep_rs1, keep_rs2;
    logic [6:0]    opc;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return p == AW'(BS - 1) ? '0 : p + 1'b1;
    endfunction

    assign count     = cnt;
    assign full      = cnt == CW'(BS);
    assign empty     = cnt == '0;
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign out_instr = mem[head];
    assign out_index = head;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Opcode classes select which register fields are real; everything else reads as x0.
    always_comb begin
        opc      = in_instr[6:0];
        st_br    = opc == 7'b0100011 || opc == 7'b1100011;
        imm      = opc == 7'b0010011 || opc == 7'b0000011 || opc == 7'b1100111;
        upper    = opc == 7'b0110111 || opc == 7'b0010111 || opc == 7'b1101111;
        op       = opc == 7'b0110011;
        keep_rd  = op || imm || upper;
        keep_rs1 = op || imm || st_br;
        keep_rs2 = op || st_br;
    end

    always_ff @(posedge clk)
        if (push && !flush) mem[tail] <= in_instr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head        <= '0;
            tail        <= '0;
            cnt         <= '0;
            alloc_valid <= 1'b0;
            alloc_index <= '0;
            alloc_rd    <= '0;
            alloc_rs1   <= '0;
            alloc_rs2   <= '0;
        end else if (flush) begin
            head        <= '0;
            tail        <= '0;
            cnt         <= '0;
            alloc_valid <= 1'b0;
        end else begin
            if (push) tail <= nxt(tail);
            if (pop) head <= nxt(head);
            cnt         <= cnt + CW'(push) - CW'(pop);
            alloc_valid <= push;
            if (push) begin
                alloc_index <= tail;
                alloc_rd    <= keep_rd  ? in_instr[7 +: RW]  : '0;
                alloc_rs1   <= keep_rs1 ? in_instr[15 +: RW] : '0;
                alloc_rs2   <= keep_rs2 ? in_instr[20 +: RW] : '0;
            end
        end
    end

`ifdef ESM_IBUF_STATS_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_q <= '0;
        else if (flush) stall_q <= '0;
        else if (in_valid && !in_ready && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_esm_instr_buffer.sv
// tb_esm_instr_buffer: queue-based reference model checked every cycle, plus directed literal checks.
module tb_esm_instr_buffer;
    localparam int BS = 32;

    logic        clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
    logic [31:0] in_instr = 0;
    logic        in_ready, alloc_valid, out_valid, full, empty;
    logic [4:0]  alloc_index, out_index;
    logic [3:0]  alloc_rd, alloc_rs1, alloc_rs2;
    logic [31:0] out_instr;
    logic [5:0]  count;
    logic [15:0] stall_cnt;

    esm_instr_buffer #(.BS(BS), .REGNUM(16), .IW(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .alloc_valid(alloc_valid), .alloc_index(alloc_index),
        .alloc_rd(alloc_rd), .alloc_rs1(alloc_rs1), .alloc_rs2(alloc_rs2),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_index(out_index), .count(count), .full(full), .empty(empty), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    typedef struct {logic [31:0] instr; int idx;} ent_t;
    ent_t q[$];
    int   m_next = 0, m_st = 0, m_aidx = 0;
    bit   m_av = 0;
    logic [3:0] m_rd = 0, m_rs1 = 0, m_rs2 = 0;

    task automatic dec(input logic [31:0] i, output logic [3:0] rd, output logic [3:0] rs1, output logic [3:0] rs2);
        rd = i[10:7]; rs1 = i[18:15]; rs2 = i[23:20];
        case (i[6:0])
            7'h33: ;
            7'h23, 7'h63: rd = 0;
            7'h13, 7'h03, 7'h67: rs2 = 0;
            7'h37, 7'h17, 7'h6F: begin rs1 = 0; rs2 = 0; end
            default: begin rd = 0; rs1 = 0; rs2 = 0; end
        endcase
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            q.delete();
            m_next = 0; m_st = 0; m_av = 0;
            if (rst) begin m_aidx = 0; m_rd = 0; m_rs1 = 0; m_rs2 = 0; end
        end else begin
            bit pu, po;
            ent_t e;
            pu = in_valid && q.size() < BS;
            po = out_ready && q.size() > 0;
            if (in_valid && q.size() == BS && m_st < 65535) m_st++;
            if (po) void'(q.pop_front());
            m_av = pu;
            if (pu) begin
                e.instr = in_instr; e.idx = m_next;
                q.push_back(e);
                m_aidx = m_next;
                dec(in_instr, m_rd, m_rs1, m_rs2);
                m_next = (m_next + 1) % BS;
            end
        end
    end

    always @(negedge clk) begin
        chk("count", 32'(count), 32'(q.size()));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("full", 32'(full), 32'(q.size() == BS));
        chk("in_ready", 32'(in_ready), 32'(q.size() < BS));
        chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            chk("out_instr", out_instr, q[0].instr);
            chk("out_index", 32'(out_index), 32'(q[0].idx));
        end
        chk("alloc_valid", 32'(alloc_valid), 32'(m_av));
        chk("alloc_index", 32'(alloc_index), 32'(m_aidx));
        chk("alloc_rd", 32'(alloc_rd), 32'(m_rd));
        chk("alloc_rs1", 32'(alloc_rs1), 32'(m_rs1));
        chk("alloc_rs2", 32'(alloc_rs2), 32'(m_rs2));
`ifdef ESM_IBUF_STATS_EN
        chk("stall_cnt", 32'(stall_cnt), 32'(m_st));
`else
        chk("stall_cnt", 32'(stall_cnt), 32'd0);
`endif
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic [31:0] i);
        in_valid = 1; in_instr = i;
        step();
        in_valid = 0;
    endtask

    task automatic do_flush();
        flush = 1;
        step();
        flush = 0;
    endtask

    logic [31:0] tbl [8] = '{32'h123452B7, 32'h0000006F, 32'h00001297, 32'h0002A303,
                             32'h00208463, 32'h00000073, 32'h012889B3, 32'h000280E7};
    int c0;

    initial begin
        step();
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_alloc_valid", 32'(alloc_valid), 0);
        rst = 0;
        step();
        push1(32'h002081B3);
        chk("add_av", 32'(alloc_valid), 1);
        chk("add_idx", 32'(alloc_index), 0);
        chk("add_rd", 32'(alloc_rd), 3);
        chk("add_rs1", 32'(alloc_rs1), 1);
        chk("add_rs2", 32'(alloc_rs2), 2);
        chk("add_count", 32'(count), 1);
        chk("add_out_valid", 32'(out_valid), 1);
        chk("add_out_instr", out_instr, 32'h002081B3);
        do_flush();
        push1(32'h00532023);
        chk("sw_idx", 32'(alloc_index), 0);
        chk("sw_rd", 32'(alloc_rd), 0);
        chk("sw_rs1", 32'(alloc_rs1), 6);
        chk("sw_rs2", 32'(alloc_rs2), 5);
        push1(32'h00140393);
        chk("addi_idx", 32'(alloc_index), 1);
        chk("addi_rd", 32'(alloc_rd), 7);
        chk("addi_rs1", 32'(alloc_rs1), 8);
        chk("addi_rs2", 32'(alloc_rs2), 0);
        step();
        chk("hold_av", 32'(alloc_valid), 0);
        chk("hold_rd", 32'(alloc_rd), 7);
        for (int i = 0; i < 8; i++) push1(tbl[i]);
        chk("trunc_ra", 32'(alloc_rd), 1);
        // Fill to full, then keep requesting for 10 more cycles.
        do_flush();
        in_valid = 1;
        for (int i = 0; i < 42; i++) begin
            in_instr = 32'hA0000000 + i;
            step();
        end
        chk("full_full", 32'(full), 1);
        chk("full_in_ready", 32'(in_ready), 0);
        chk("full_count", 32'(count), 32);
        chk("full_head", 32'(out_index), 0);
`ifdef ESM_IBUF_STATS_EN
        chk("stall10", 32'(stall_cnt), 10);
`else
        chk("stall10", 32'(stall_cnt), 0);
`endif
        out_ready = 1;
        step();
        out_ready = 0; in_valid = 0;
        chk("pop_count", 32'(count), 31);
        chk("pop_in_ready", 32'(in_ready), 1);
        chk("pop_head", 32'(out_index), 1);
        do_flush();
        for (int i = 0; i < 3; i++) push1(tbl[i]);
        c0 = 32'(count);
        in_valid = 1; out_ready = 1;
        for (int i = 0; i < 70; i++) begin
            in_instr = tbl[i % 8] ^ (i << 27);
            step();
        end
        in_valid = 0; out_ready = 0;
        chk("stream_count", 32'(count), 32'(c0));
        for (int i = 0; i < 5; i++) push1(tbl[i]);
        flush = 1; in_valid = 1; in_instr = 32'h002081B3;
        step();
        flush = 0; in_valid = 0;
        chk("flush_count", 32'(count), 0);
        chk("flush_empty", 32'(empty), 1);
        chk("flush_av", 32'(alloc_valid), 0);
        push1(32'h002081B3);
        chk("flush_idx", 32'(alloc_index), 0);
        push1(32'h00140393);
        @(posedge clk);
        #2 rst = 1;
        #1;
        chk("arst_count", 32'(count), 0);
        chk("arst_empty", 32'(empty), 1);
        chk("arst_idx", 32'(alloc_index), 0);
        chk("arst_rd", 32'(alloc_rd), 0);
        step();
        rst = 0;
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/esm_instr_buffer.md
Name: esm_instr_buffer

Overview:
Circular instruction buffer directly upstream of the dependency-tracking table. Accepts raw 32-bit RV32 instructions and stores each one in a slot. For every accepted instruction it publishes the slot index plus the decoded rd/rs1/rs2, with fields an opcode does not use forced to x0, so the table can record writers/readers per slot. Entries drain in order to the issue stage through a valid/ready port.

Parameters:
BS, 32, number of buffer slots (any value >= 2; not required to be a power of 2)
REGNUM, 16, architectural register count; register fields are truncated to $clog2(REGNUM) bits
IW, 32, instruction width

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
flush  input  1  synchronous clear of all entries
in_valid  input  1  upstream instruction valid
in_ready  output  1  buffer can accept this cycle
in_instr  input  IW  instruction word
alloc_valid  output  1  one-cycle pulse: alloc_* describe a newly written slot
alloc_index  output  $clog2(BS)  slot written
alloc_rd  output  $clog2(REGNUM)  decoded destination (0 = none)
alloc_rs1  output  $clog2(REGNUM)  decoded source 1 (0 = none)
alloc_rs2  output  $clog2(REGNUM)  decoded source 2 (0 = none)
out_valid  output  1  head entry available
out_ready  input  1  consumer takes head entry
out_instr  output  IW  instruction at head
out_index  output  $clog2(BS)  slot index of head
count  output  $clog2(BS+1)  occupied slots
full  output  1  count == BS
empty  output  1  count == 0
stall_cnt  output  16  input-stall statistics (see Optional Feature)

Behaviour:
- State: storage mem[0:BS-1] (not reset), head, tail, count.
- Reset values: head = tail = count = 0; alloc_valid = 0; alloc_index, alloc_rd, alloc_rs1, alloc_rs2 = 0; stall counter = 0.
  - Derived at reset: empty = 1, full = 0, in_ready = 1, out_valid = 0.
- in_ready = !full. It depends only on registered count, so there is no same-cycle pop-to-push bypass.
- push = in_valid & in_ready. On push:
  - mem[tail] <= in_instr.
  - tail advances; it wraps from BS-1 to 0 explicitly.
- Decode is registered and visible 1 cycle after push: alloc_valid = 1, alloc_index = tail value at push, alloc_* = decoded fields. If there is no push, alloc_valid = 0 and the other alloc_* outputs hold their previous values.
- Field decode:
  - rd = instr[11:7], rs1 = instr[19:15], rs2 = instr[24:20], each truncated to the low $clog2(REGNUM) bits.
  - STORE (0100011), BRANCH (1100011): rd = 0.
  - OP-IMM (0010011), LOAD (0000011), JALR (1100111): rs2 = 0.
  - LUI (0110111), AUIPC (0010111), JAL (1101111): rs1 = rs2 = 0.
  - OP (0110011): all three fields kept.
  - Any other opcode: rd = rs1 = rs2 = 0.
- Drain port: out_valid = !empty; out_instr = mem[head]; out_index = head.
- pop = out_valid & out_ready. On pop, head advances with the same wrap rule as tail.
- A newly pushed entry becomes visible at the head no earlier than the cycle after the push (no bypass when empty).
- Count update: push only +1; pop only -1; push and pop together leave count unchanged.
- When full, a pop that cycle frees a slot but in_ready stays 0 until the next cycle.
- flush has priority over push and pop: head = tail = count = 0, alloc_valid = 0 next cycle, incoming instruction dropped.
- rst asserted mid-operation: all registers return immediately (asynchronously) to their reset values; contents of mem are irrelevant afterwards.

Optional Feature:
- Macro: ESM_IBUF_STATS_EN.
- Defined: 16-bit counter increments every cycle with in_valid & !in_ready, saturates at 16'hFFFF, cleared by rst and flush. stall_cnt reflects this counter.
- Undefined: no counter logic; stall_cnt tied to 0.

Test Plan:
- Reset, then push ADD x3,x1,x2 (0x002081B3) -> next cycle alloc_valid=1, alloc_index=0, rd=3, rs1=1, rs2=2; count=1; out_valid=1, out_instr=0x002081B3.
- Push SW x5,0(x6) (0x00532023), then ADDI x7,x8,1 (0x00140393) -> first: rd=0, rs1=6, rs2=5; second: rd=7, rs1=8, rs2=0; alloc_index 0 then 1.
- Push 32 instructions with out_ready=0 -> full=1, in_ready=0, count=32; a 33rd in_valid is not accepted. Then 1 cycle of out_ready=1 -> out_index=0 pops, count=31, in_ready=1 the following cycle.
- Steady stream with in_valid=out_ready=1 for 70 cycles -> count constant, tail and head wrap 31->0, alloc_index sequence wraps 31,0,1.
- Assert flush with 5 entries and simultaneous push -> next cycle count=0, empty=1, alloc_valid=0; next push gets alloc_index=0.
- With ESM_IBUF_STATS_EN: hold full with in_valid=1 for 10 cycles -> stall_cnt=10. Without the macro -> stall_cnt=0.
